spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame length in bits (range 4..32).
REQ-002 SHALL have parameter CLKDIV, default 4, SCLK half-period in clk cycles (range 2..255).
REQ-003 SHALL have parameter NCS, default 1, number of chip selects (range 1..8); CSW = max(1, clog2(NCS)).
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start  input  1 (frame request pulse); datain  input  DATA_W (transmit word); cs_sel  input  CSW (target device).
REQ-007 SHALL have ports cpol  input  1 (SCLK idle level); cpha  input  1 (clock phase); hold  input  1 (keep CS asserted after the frame for bursts).
REQ-008 SHALL have ports sclk  output  1; mosi  output  1; miso  input  1; ncs  output  NCS (active-low chip selects).
REQ-009 SHALL have ports busy  output  1; done  output  1 (one-cycle pulse); dataout  output  DATA_W (received word).

Function
REQ-010 States SHALL be IDLE, LEAD, XFER, WAIT, TRAIL.
REQ-011 IDLE: start=1 latches datain, cs_sel, cpol, cpha and hold, then enters LEAD; cpol/cpha/cs_sel changes outside IDLE SHALL be ignored.
REQ-012 LEAD SHALL last CLKDIV cycles with ncs[cs_sel]=0 and sclk=cpol; mosi SHALL present datain MSB.
REQ-013 XFER SHALL last 2*DATA_W*CLKDIV cycles, MSB first, each bit spanning two half-periods.
REQ-014 CPHA=0: sclk=cpol in the first half of each bit and ~cpol in the second; miso sampled at the leading edge, mosi updated at the trailing edge.
REQ-015 CPHA=1: sclk=~cpol in the first half of each bit and cpol in the second; mosi updated at the leading edge, miso sampled at the trailing edge.
REQ-016 On leaving XFER, done SHALL pulse for exactly one cycle and dataout SHALL update to the received word, then hold it until the next done.
REQ-017 After XFER: latched hold=0 -> TRAIL; latched hold=1 -> WAIT.
REQ-018 TRAIL SHALL last CLKDIV cycles with CS still asserted and sclk=cpol, then deassert all ncs and enter IDLE.
REQ-019 WAIT: CS stays asserted, busy=0; start=1 latches datain and hold and enters XFER directly (no LEAD, cs_sel ignored); otherwise hold=0 -> TRAIL.
REQ-020 busy SHALL be 1 in LEAD, XFER and TRAIL, and 0 in IDLE and WAIT; start while busy=1 SHALL be ignored.
REQ-021 cs_sel >= NCS SHALL run the frame with no ncs bit asserted.
REQ-022 Latency for DATA_W=8, CLKDIV=4, start sampled at edge T: ncs low at T+1, done at T+69, busy low at T+73.

Reset
REQ-023 reset=1 SHALL, at any time including mid-frame, force IDLE, ncs all 1, sclk=0, mosi=0, busy=0, done=0, dataout=0, all counters 0.
REQ-024 The first start after reset release SHALL behave as from IDLE.

Configuration
REQ-025 Macro SPI_MASTER_RX_EN defined: the miso receive shift register is built and dataout behaves per REQ-016.
REQ-026 Macro SPI_MASTER_RX_EN undefined: no receive logic, miso ignored, dataout constant 0; all other behaviour unchanged.

Verification
REQ-027 Mode 0 (cpol=0, cpha=0), datain=8'hA5, miso driven from 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; done at T+69; dataout=8'h3C.
REQ-028 Mode 3 (cpol=1, cpha=1), datain=8'h81, miso from 8'h7E -> sclk idles 1; 8 rising edges used for sampling; dataout=8'h7E.
REQ-029 hold=1 with two starts (8'h11, 8'h22), NCS=4, cs_sel=2 -> ncs=4'b1011 continuously across both frames; two done pulses; ncs=4'hF after TRAIL.
REQ-030 start asserted at T+10 during a busy frame -> ignored; exactly one done.
REQ-031 reset asserted at T+30 mid-XFER -> ncs=all 1, sclk=0, busy=0, no done; next start completes normally.
REQ-032 Build without SPI_MASTER_RX_EN, miso toggling -> dataout stays 0; mosi and timing are identical to REQ-027.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: modes 0-3, NCS chip selects, CS hold for bursts.
// Define SPI_MASTER_RX_EN to build the miso receive path.
module spi_master #(
    parameter int DATA_W = 8,
    parameter int CLKDIV = 4,
    parameter int NCS    = 1,
    localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] datain,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              hold,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NCS-1:0]    ncs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dataout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_WAIT,
        S_TRAIL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_div;
    logic              r_ph;
    logic [4:0]        r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [CSW-1:0]    r_cs;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_hold;
    logic              r_done;
    logic              w_div_end;
    logic              w_bit_end;
    logic              w_last;
    logic              w_act;

    assign w_div_end = (r_div == 8'(CLKDIV - 1));
    assign w_bit_end = w_div_end & r_ph;
    assign w_last    = w_bit_end & (r_bit == 5'(DATA_W - 1));
    assign w_act     = (r_state != S_IDLE);
    assign done      = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        sclk   = r_cpol;
        mosi   = 1'b0;
        ncs    = '1;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LEAD;
            S_LEAD: begin
                busy = 1'b1;
                if (w_div_end) w_next = S_XFER;
            end
            S_XFER: begin
                busy = 1'b1;
                sclk = r_cpol ^ r_ph ^ r_cpha;
                if (w_last) w_next = r_hold ? S_WAIT : S_TRAIL;
            end
            S_WAIT: begin
                if (start)      w_next = S_XFER;
                else if (!hold) w_next = S_TRAIL;
            end
            S_TRAIL: begin
                busy = 1'b1;
                if (w_div_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_act) mosi = r_tx[DATA_W-1];
        for (int i = 0; i < NCS; i++)
            ncs[i] = !(w_act && (r_cs == CSW'(i)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_ph   <= 1'b0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_cs   <= '0;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_hold <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Idle SCLK tracks cpol so the first frame has no stray edge
                    r_cpol <= cpol;
                    if (start) begin
                        r_tx   <= datain;
                        r_cs   <= cs_sel;
                        r_cpha <= cpha;
                        r_hold <= hold;
                    end
                end
                S_LEAD, S_TRAIL: r_div <= w_div_end ? '0 : r_div + 8'd1;
                S_XFER: begin
                    r_div <= w_div_end ? '0 : r_div + 8'd1;
                    if (w_div_end) r_ph <= ~r_ph;
                    if (w_bit_end) begin
                        r_bit <= w_last ? '0 : r_bit + 5'd1;
                        r_tx  <= r_tx << 1;
                    end
                    if (w_last) r_done <= 1'b1;
                end
                S_WAIT: begin
                    if (start) begin
                        r_tx   <= datain;
                        r_hold <= hold;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_dataout;

    assign dataout = r_dataout;

    // Sampling always lands mid-bit, whichever edge that is for the mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx      <= '0;
            r_dataout <= '0;
        end else if (r_state == S_XFER && w_div_end) begin
            if (!r_ph)  r_rx      <= {r_rx[DATA_W-2:0], miso};
            if (w_last) r_dataout <= r_rx;
        end
    end
`else
    logic w_unused_miso;

    assign w_unused_miso = miso;
    assign dataout       = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master against a cycle-offset reference model.
// Runs an NCS=4 and an NCS=3 instance in parallel on shared stimulus.
module tb_spi_master;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] datain;
    logic [1:0]   cs_sel;
    logic         cpol;
    logic         cpha;
    logic         hold;
    logic         miso;
    logic         sclk, mosi, busy, done;
    logic [3:0]   ncs;
    logic [W-1:0] dataout;
    logic         sclk3, mosi3, busy3, done3;
    logic [2:0]   ncs3;
    logic [W-1:0] dout3;
    logic [W-1:0] exp_dout;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(W), .CLKDIV(D), .NCS(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .datain(datain),
        .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .hold(hold),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ncs(ncs),
        .busy(busy), .done(done), .dataout(dataout)
    );

    spi_master #(.DATA_W(W), .CLKDIV(D), .NCS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .datain(datain),
        .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .hold(hold),
        .sclk(sclk3), .mosi(mosi3), .miso(miso), .ncs(ncs3),
        .busy(busy3), .done(done3), .dataout(dout3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] ncs_exp(input int nc, input int cs,
                                            input bit act);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nc; i++) v[i] = !(act && cs == i);
        return v;
    endfunction

    task automatic check_outs(input logic es, input bit cm, input logic em,
                              input int cs, input bit act,
                              input logic eb, input logic ed);
        chk("sclk", 32'(sclk), 32'(es));
        chk("sclk3", 32'(sclk3), 32'(es));
        if (cm) begin
            chk("mosi", 32'(mosi), 32'(em));
            chk("mosi3", 32'(mosi3), 32'(em));
        end
        chk("ncs", 32'(ncs), ncs_exp(4, cs, act));
        chk("ncs3", 32'(ncs3), ncs_exp(3, cs, act));
        chk("busy", 32'(busy), 32'(eb));
        chk("busy3", 32'(busy3), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("done3", 32'(done3), 32'(ed));
        chk("dout", 32'(dataout), 32'(exp_dout));
        chk("dout3", 32'(dout3), 32'(exp_dout));
    endtask

    task automatic burst(input int n, input int cs, input bit pol,
                         input bit pha, input logic [7:0] t0,
                         input logic [7:0] r0, input bit poke);
        logic [7:0] tx[3];
        logic [7:0] rx[3];
        int         lead, len, x, b, h;
        logic       es;
        for (int i = 0; i < 3; i++) begin
            tx[i] = 8'($urandom);
            rx[i] = 8'($urandom);
        end
        tx[0] = t0;
        rx[0] = r0;
        @(negedge clk);
        start  = 1'b1;
        datain = tx[0];
        cs_sel = 2'(cs);
        cpol   = pol;
        cpha   = pha;
        hold   = (n > 1);
        miso   = rx[0][7];
        @(posedge clk);
        for (int f = 0; f < n; f++) begin
            lead = (f == 0) ? D : 0;
            len  = lead + 2 * W * D;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                start  = (poke && f == 0 && c == 9);
                datain = 8'($urandom);
                cs_sel = 2'($urandom);
                cpol   = 1'($urandom);
                cpha   = 1'($urandom);
                hold   = 1'($urandom);
                x = c - lead;
                if (x < 0) begin
                    es = pol;
                    b  = 0;
                end else begin
                    b  = x / (2 * D);
                    h  = (x / D) % 2;
                    es = pha ? ((h == 1) ? pol : !pol)
                             : ((h == 1) ? !pol : pol);
                end
                check_outs(es, 1'b1, tx[f][7-b], cs, 1'b1, 1'b1, 1'b0);
                miso = rx[f][7-b];
            end
            @(negedge clk);
`ifdef SPI_MASTER_RX_EN
            exp_dout = rx[f];
`endif
            check_outs(pol, 1'b0, 1'b0, cs, 1'b1, (f == n - 1), 1'b1);
            if (f < n - 1) begin
                start  = 1'b1;
                datain = tx[f+1];
                hold   = (f + 1 < n - 1);
                miso   = rx[f+1][7];
                @(posedge clk);
            end else begin
                start = 1'b0;
            end
        end
        for (int c = 1; c < D; c++) begin
            @(negedge clk);
            check_outs(pol, 1'b0, 1'b0, cs, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        check_outs(pol, 1'b1, 1'b0, cs, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        start  = 1'b1;
        datain = 8'($urandom);
        cs_sel = 2'd1;
        cpol   = 1'b1;
        cpha   = 1'b0;
        hold   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_dout = '0;
        check_outs(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_outs(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        datain   = '0;
        cs_sel   = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        hold     = 1'b0;
        miso     = 1'b0;
        exp_dout = '0;
        repeat (3) @(negedge clk);
        check_outs(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outs(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        burst(1, 0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0);
        burst(1, 1, 1'b1, 1'b1, 8'h81, 8'h7E, 1'b0);
        burst(2, 2, 1'b0, 1'b0, 8'h11, 8'($urandom), 1'b0);
        burst(1, 0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
        mid_reset();
        burst(1, 1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        burst(1, 3, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        burst(3, 3, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
        for (int k = 0; k < 12; k++)
            burst($urandom_range(1, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
